// File: rtl/wb_test_memory_pkg.sv
// Shared types and helpers for the Wishbone test memory: FSM encoding,
// default fill value for unmapped reads, and the address-window decoder.
package wb_test_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } stateT;

  localparam logic [15:0] DEFAULT_UNMAPPED = 16'hDEAD;

  typedef struct packed {
    logic        hit;
    logic [31:0] offset;
  } decodeT;

  // Hit only when the address is inside [start, last] and its offset falls
  // within the implemented depth of that window.
  function automatic decodeT decodeWindow(
    input logic [31:0] adr,
    input logic [31:0] start,
    input logic [31:0] last,
    input logic [31:0] depth
  );
    decodeT d;
    d.offset = adr - start;
    d.hit    = (adr >= start) && (adr <= last) && (d.offset < depth);
    return d;
  endfunction

endpackage

// File: rtl/wb_test_memory_progmem_ram.sv
// Program memory: single write port and a registered read port with
// read-first behaviour, so a same-edge write is not seen by the read.
module wb_test_memory_progmem_ram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wAdr,
  input  logic [15:0]   wDat,
  input  logic          re,
  input  logic [AW-1:0] rAdr,
  output logic [15:0]   rDat
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAdr] <= wDat;
  end

  always_ff @(posedge clk) begin
    if (re) rDat <= mem[rAdr];
  end

endmodule

// File: rtl/wb_test_memory.sv
// Wishbone classic slave holding the test program memory and a bank of
// 16-bit test registers, with a programmable number of wait states.
module wb_test_memory
  import wb_test_memory_pkg::*;
#(
  parameter int          ADDRESS_WIDTH    = 24,
  parameter logic [31:0] PROGMEM_START    = 32'h10000,
  parameter logic [31:0] PROGMEM_END      = 32'h1FFFF,
  parameter int          PROGMEM_DEPTH    = 1024,
  parameter logic [31:0] REGMEM_START     = 32'h00000,
  parameter logic [31:0] REGMEM_END       = 32'h0FFFF,
  parameter int          REG_COUNT        = 16,
  parameter int          WAIT_STATES      = 0,
  parameter int          PROGMEM_WRITABLE = 0,
  parameter logic [15:0] UNMAPPED_VALUE   = DEFAULT_UNMAPPED,
  localparam int PA = $clog2(PROGMEM_DEPTH),
  localparam int RA = $clog2(REG_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_WIDTH-1:0]  wbAdrI,
  input  logic [15:0]               wbDatI,
  output logic [15:0]               wbDatO,
  input  logic                      wbCycI,
  input  logic                      wbStbI,
  input  logic                      wbWeI,
  output logic                      wbAckO,
  input  logic                      loadEn,
  input  logic [PA-1:0]             loadAdr,
  input  logic [15:0]               loadDat,
  input  logic                      extWe,
  input  logic [RA-1:0]             extAdr,
  input  logic [15:0]               extDat,
  output logic [16*REG_COUNT-1:0]   regOut
);

  stateT                    stateReg, stateNext;
  logic [7:0]               cntReg, cntNext;
  logic [ADDRESS_WIDTH-1:0] adrReg;
  logic                     weReg;
  logic [15:0]              datReg;
  logic                     enterAck;
  logic                     req;

  assign req = wbCycI & wbStbI;

  // With zero wait states the access completes on the sampling edge itself,
  // so in IDLE the live bus values are used instead of the latched ones.
  logic [ADDRESS_WIDTH-1:0] curAdr;
  logic                     curWe;
  logic [15:0]              curDat;
  assign curAdr = (stateReg == IDLE) ? wbAdrI : adrReg;
  assign curWe  = (stateReg == IDLE) ? wbWeI  : weReg;
  assign curDat = (stateReg == IDLE) ? wbDatI : datReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      adrReg   <= '0;
      weReg    <= 1'b0;
      datReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (stateReg == IDLE && req) begin
        adrReg <= wbAdrI;
        weReg  <= wbWeI;
        datReg <= wbDatI;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    enterAck  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            stateNext = ACK;
            enterAck  = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = 8'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          stateNext = IDLE;
        end else if (cntReg == 8'd0) begin
          stateNext = ACK;
          enterAck  = 1'b1;
        end else begin
          cntNext = cntReg - 8'd1;
        end
      end
      ACK:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  decodeT        progDec, regDec;
  logic [PA-1:0] progIdx;
  logic [RA-1:0] regIdx;
  assign progDec = decodeWindow(32'(curAdr), PROGMEM_START, PROGMEM_END, 32'(PROGMEM_DEPTH));
  assign regDec  = decodeWindow(32'(curAdr), REGMEM_START, REGMEM_END, 32'(REG_COUNT));
  assign progIdx = PA'(progDec.offset);
  assign regIdx  = RA'(regDec.offset);

  logic wbProgWe, wbRegWe, readAck;
  assign wbProgWe = enterAck & curWe & progDec.hit & (PROGMEM_WRITABLE != 0);
  assign wbRegWe  = enterAck & curWe & regDec.hit;
  assign readAck  = enterAck & ~curWe;

  logic          ramWe, ramRe;
  logic [PA-1:0] ramWAdr;
  logic [15:0]   ramWDat, ramDat;
  assign ramWe   = ~rst & (loadEn | wbProgWe);
  assign ramWAdr = loadEn ? loadAdr : progIdx;
  assign ramWDat = loadEn ? loadDat : curDat;
  assign ramRe   = ~rst & readAck & progDec.hit;

  wb_test_memory_progmem_ram #(.DEPTH(PROGMEM_DEPTH)) progMem (
    .clk  (clk),
    .we   (ramWe),
    .wAdr (ramWAdr),
    .wDat (ramWDat),
    .re   (ramRe),
    .rAdr (progIdx),
    .rDat (ramDat)
  );

  logic [15:0] regs [REG_COUNT];

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : gReg
    logic [15:0] r;
    always_ff @(posedge clk) begin
      if (rst)                                  r <= '0;
      else if (extWe && extAdr == RA'(gi))      r <= extDat;
      else if (wbRegWe && regIdx == RA'(gi))    r <= curDat;
    end
    assign regs[gi]            = r;
    assign regOut[16*gi +: 16] = r;
  end

  // Program reads come straight from the RAM output register; everything
  // else is captured here. selRam remembers which source the last read used.
  logic        selRam;
  logic [15:0] dataReg;
  always_ff @(posedge clk) begin
    if (rst) begin
      selRam  <= 1'b0;
      dataReg <= '0;
    end else if (readAck) begin
      selRam  <= progDec.hit;
      dataReg <= regDec.hit ? regs[regIdx] : UNMAPPED_VALUE;
    end
  end

  assign wbDatO = selRam ? ramDat : dataReg;
  assign wbAckO = (stateReg == ACK);

endmodule

// File: tb/tb_wb_test_memory.sv
// Bench for wb_test_memory: two instances (0 and 3 wait states) sharing the
// side ports, checked with directed vectors, corner sequences and random traffic.
module tb_wb_test_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [23:0]  adr;
  logic [15:0]  dat;
  logic         we;
  logic [1:0]   cyc, stb, ack;
  logic [15:0]  datO [2];
  logic [255:0] regOut [2];
  logic         loadEn;
  logic [9:0]   loadAdr;
  logic [15:0]  loadDat;
  logic         extWe;
  logic [3:0]   extAdr;
  logic [15:0]  extDat;

  int total = 0;
  int bad   = 0;

  logic [15:0] progModel [1024];
  logic [15:0] regModel  [2][16];

  wb_test_memory #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wbAdrI(adr), .wbDatI(dat), .wbDatO(datO[0]),
    .wbCycI(cyc[0]), .wbStbI(stb[0]), .wbWeI(we), .wbAckO(ack[0]),
    .loadEn(loadEn), .loadAdr(loadAdr), .loadDat(loadDat),
    .extWe(extWe), .extAdr(extAdr), .extDat(extDat), .regOut(regOut[0])
  );

  wb_test_memory #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .wbAdrI(adr), .wbDatI(dat), .wbDatO(datO[1]),
    .wbCycI(cyc[1]), .wbStbI(stb[1]), .wbWeI(we), .wbAckO(ack[1]),
    .loadEn(loadEn), .loadAdr(loadAdr), .loadDat(loadDat),
    .extWe(extWe), .extAdr(extAdr), .extDat(extDat), .regOut(regOut[1])
  );

  function automatic int waitStates(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] packRegs(input int d);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = regModel[d][i];
    return v;
  endfunction

  // Reference view of the memory map.
  function automatic logic [15:0] expRead(input int d, input logic [23:0] a);
    int ai;
    ai = int'(a);
    if (ai >= 'h10000 && ai <= 'h1FFFF)
      return (ai - 'h10000 < 1024) ? progModel[ai - 'h10000] : 16'hDEAD;
    if (ai <= 'hFFFF)
      return (ai < 16) ? regModel[d][ai] : 16'hDEAD;
    return 16'hDEAD;
  endfunction

  task automatic modelWrite(input int d, input logic [23:0] a, input logic [15:0] wd);
    if (int'(a) < 16) regModel[d][int'(a)] = wd;
  endtask

  task automatic xfer(input int d, input logic [23:0] a, input logic w, input logic [15:0] wd,
                      output logic [15:0] rd, output int lat);
    @(negedge clk);
    adr = a; we = w; dat = wd; cyc[d] = 1'b1; stb[d] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[d] && lat < 50);
    rd = datO[d];
    if (!ack[d]) begin
      total++; bad++;
      $display("FAIL ack timeout dut%0d adr=%h", d, a);
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we = 1'b0;
    $display("xfer dut%0d adr=%h we=%0d wdat=%h rdat=%h lat=%0d", d, a, w, wd, rd, lat);
  endtask

  task automatic doXfer(input int d, input logic [23:0] a, input logic w, input logic [15:0] wd);
    logic [15:0] rd, exp;
    int lat;
    exp = expRead(d, a);
    xfer(d, a, w, wd, rd, lat);
    check("latency", 256'(lat), 256'(waitStates(d) + 1));
    if (!w) check("read data", 256'(rd), 256'(exp));
    else modelWrite(d, a, wd);
    check("regOut", regOut[d], packRegs(d));
  endtask

  task automatic extWrite(input logic [3:0] i, input logic [15:0] v);
    @(negedge clk);
    extWe = 1'b1; extAdr = i; extDat = v;
    @(negedge clk);
    extWe = 1'b0;
    regModel[0][i] = v; regModel[1][i] = v;
    $display("ext write reg%0d=%h", i, v);
  endtask

  task automatic loadWord(input logic [9:0] i, input logic [15:0] v);
    @(negedge clk);
    loadEn = 1'b1; loadAdr = i; loadDat = v;
    @(negedge clk);
    loadEn = 1'b0;
    progModel[i] = v;
    $display("load word %0d=%h", i, v);
  endtask

  typedef struct {
    int          d;
    logic [23:0] a;
    logic        w;
    logic [15:0] wd;
    logic        chk;
    logic [15:0] expDat;
    int          expLat;
  } vecT;

  vecT         vec [16];
  logic [15:0] rd;
  int          lat;
  logic        sawAck;

  initial begin
    vec[0]  = '{0, 24'h10000, 1'b0, 16'h0000, 1'b1, 16'h0001, 1};
    vec[1]  = '{0, 24'h10001, 1'b0, 16'h0000, 1'b1, 16'h0005, 1};
    vec[2]  = '{0, 24'h10002, 1'b0, 16'h0000, 1'b1, 16'h1234, 1};
    vec[3]  = '{1, 24'h00005, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 4};
    vec[4]  = '{1, 24'h00005, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 4};
    vec[5]  = '{0, 24'h20000, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1};
    vec[6]  = '{0, 24'h00010, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1};
    vec[7]  = '{1, 24'h20000, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 4};
    vec[8]  = '{0, 24'h00010, 1'b1, 16'h4321, 1'b0, 16'h0000, 1};
    vec[9]  = '{0, 24'h00010, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1};
    vec[10] = '{0, 24'h10000, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1};
    vec[11] = '{0, 24'h10000, 1'b0, 16'h0000, 1'b1, 16'h0001, 1};
    vec[12] = '{0, 24'h1FFFF, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1};
    vec[13] = '{0, 24'h10400, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1};
    vec[14] = '{1, 24'h0000F, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 4};
    vec[15] = '{1, 24'h0000F, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 4};

    rst = 1'b1; adr = '0; dat = '0; we = 1'b0; cyc = '0; stb = '0;
    loadEn = 1'b0; loadAdr = '0; loadDat = '0; extWe = 1'b0; extAdr = '0; extDat = '0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) regModel[d][i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check("reset ack", 256'(ack[d]), 256'(0));
      check("reset datO", 256'(datO[d]), 256'(0));
      check("reset regOut", regOut[d], 256'(0));
    end

    // Fill the whole program memory, then the directed words.
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      loadEn = 1'b1; loadAdr = 10'(i); loadDat = 16'($urandom);
      progModel[i] = loadDat;
      @(negedge clk);
    end
    loadEn = 1'b0;
    loadWord(10'd0, 16'h0001);
    loadWord(10'd1, 16'h0005);
    loadWord(10'd2, 16'h1234);

    for (int v = 0; v < 16; v++) begin
      xfer(vec[v].d, vec[v].a, vec[v].w, vec[v].wd, rd, lat);
      check("vec latency", 256'(lat), 256'(vec[v].expLat));
      if (vec[v].chk) check("vec data", 256'(rd), 256'(vec[v].expDat));
      if (vec[v].w) modelWrite(vec[v].d, vec[v].a, vec[v].wd);
      check("vec regOut", regOut[vec[v].d], packRegs(vec[v].d));
    end
    check("reg5 slice", 256'(regOut[1][95:80]), 256'(16'hBEEF));

    // Strobe dropped during the wait phase: no ACK, no write.
    @(negedge clk);
    adr = 24'h00006; we = 1'b1; dat = 16'h7777; cyc[1] = 1'b1; stb[1] = 1'b1;
    sawAck = 1'b0;
    repeat (2) begin @(negedge clk); sawAck |= ack[1]; end
    cyc[1] = 1'b0; stb[1] = 1'b0; we = 1'b0;
    repeat (6) begin @(negedge clk); sawAck |= ack[1]; end
    $display("abort write dut1 adr=000006");
    check("abort ack", 256'(sawAck), 256'(0));
    check("abort regOut", regOut[1], packRegs(1));
    doXfer(1, 24'h00006, 1'b0, 16'h0);

    // Wishbone and DUT-side write to reg 3 on the same edge.
    @(negedge clk);
    adr = 24'h00003; we = 1'b1; dat = 16'h1111; cyc[0] = 1'b1; stb[0] = 1'b1;
    extWe = 1'b1; extAdr = 4'd3; extDat = 16'h2222;
    @(negedge clk);
    check("collide ack", 256'(ack[0]), 256'(1));
    cyc[0] = 1'b0; stb[0] = 1'b0; we = 1'b0; extWe = 1'b0;
    regModel[0][3] = 16'h2222; regModel[1][3] = 16'h2222;
    $display("collide write reg3 wb=1111 ext=2222");
    check("collide reg3", 256'(regOut[0][63:48]), 256'(16'h2222));
    check("collide regOut", regOut[0], packRegs(0));

    // Read-during-write returns the old contents.
    extWrite(4'd7, 16'h1357);
    @(negedge clk);
    adr = 24'h00007; cyc[0] = 1'b1; stb[0] = 1'b1;
    extWe = 1'b1; extAdr = 4'd7; extDat = 16'h5A5A;
    @(negedge clk);
    check("rdw reg data", 256'(datO[0]), 256'(16'h1357));
    cyc[0] = 1'b0; stb[0] = 1'b0; extWe = 1'b0;
    regModel[0][7] = 16'h5A5A; regModel[1][7] = 16'h5A5A;
    $display("read-during-write reg7 old=1357 new=5A5A");
    check("rdw regOut", regOut[0], packRegs(0));

    @(negedge clk);
    adr = 24'h10001; cyc[0] = 1'b1; stb[0] = 1'b1;
    loadEn = 1'b1; loadAdr = 10'd1; loadDat = 16'h9999;
    @(negedge clk);
    check("rdw prog data", 256'(datO[0]), 256'(16'h0005));
    cyc[0] = 1'b0; stb[0] = 1'b0; loadEn = 1'b0;
    progModel[1] = 16'h9999;
    $display("read-during-load word1 old=0005 new=9999");
    doXfer(0, 24'h10001, 1'b0, 16'h0);

    // Reset while a write is waiting.
    doXfer(1, 24'h10002, 1'b0, 16'h0);
    @(negedge clk);
    adr = 24'h00009; we = 1'b1; dat = 16'h4444; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("reset during write dut1 adr=000009");
    check("rst ack", 256'(ack[1]), 256'(0));
    check("rst datO0", 256'(datO[0]), 256'(0));
    check("rst datO1", 256'(datO[1]), 256'(0));
    check("rst regOut0", regOut[0], 256'(0));
    check("rst regOut1", regOut[1], 256'(0));
    rst = 1'b0; cyc = '0; stb = '0; we = 1'b0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) regModel[d][i] = '0;
    doXfer(1, 24'h10002, 1'b0, 16'h0);
    doXfer(1, 24'h00009, 1'b0, 16'h0);
    doXfer(0, 24'h10000, 1'b0, 16'h0);

    for (int n = 0; n < 200; n++) begin
      int d, sel;
      logic [23:0] a;
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) extWrite(4'($urandom), 16'($urandom));
      if (sel == 1) loadWord(10'($urandom), 16'($urandom));
      case ($urandom_range(0, 3))
        0:       a = 24'($urandom_range(0, 20));
        1:       a = 24'('h10000 + $urandom_range(0, 5));
        2:       a = 24'('h10000 + $urandom_range(1018, 1030));
        default: a = 24'($urandom_range('h20000, 'hFFFFFF));
      endcase
      doXfer(d, a, 1'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
